// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state type and parameter helpers for the SRAM RW-port controller
package sram_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Bits covered by one write-mask bit.
    function automatic int granule_w(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

    // The mask must split the word exactly, and the response FIFO needs room for at least two reads.
    function automatic bit params_ok(input int data_w, input int mask_w, input int resp_depth);
        return (data_w % mask_w == 0) && (resp_depth >= 2);
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// sram_ctrl_rsp_fifo: synchronous response FIFO holding captured SRAM read data
// Ports:
//   clock, reset  - clock and synchronous active-high reset (empties the FIFO)
//   push/push_data - enqueue one word
//   pop           - dequeue the head word
//   head          - current head word (stable until popped)
//   count         - number of stored words
module sram_ctrl_rsp_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: valid/ready request stream to single-port masked SRAM RW0 cycles
// Optional feature macro: SRAM_CTRL_ZERO_INIT_EN (zero-fill the whole array after reset).
// Ports:
//   clock, reset          - sole clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_we selects write (1) or read (0)
//   req_addr/wmask/wdata  - word address, per-granule write enable, write data
//   rsp_valid/rsp_ready   - read response handshake, rsp_rdata is the FIFO head
//   init_done             - controller accepts traffic
//   sram_*                - RW0 port of the macro; sram_clk mirrors clock
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 256,
    parameter int MASK_W     = 32,
    parameter int RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              sram_clk,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    if (!params_ok(DATA_W, MASK_W, RESP_DEPTH)) begin : g_param_check
        $error("sram_rw_port_ctrl: DATA_W must be a multiple of MASK_W and RESP_DEPTH >= 2");
    end

    state_e           state_q, state_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt;
    logic             run, rd_credit, accept;

`ifdef SRAM_CTRL_ZERO_INIT_EN
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              sweep;
`endif

    assign sram_clk = clock;

    // Read credit counts the word still inside the macro, so the FIFO can never overflow
    // and req_ready never depends on rsp_ready.
    always_comb begin
        run        = (state_q == ST_RUN) && !reset;
        rd_credit  = (int'(fifo_cnt) + int'(inflight_q)) < RESP_DEPTH;
        req_ready  = run && (req_we || rd_credit);
        accept     = req_valid && req_ready;
        inflight_d = accept && !req_we;
        init_done  = run;
        sram_en    = accept;
        sram_wmode = accept && req_we;
        sram_addr  = accept ? req_addr : '0;
        sram_wmask = accept ? req_wmask : '0;
        sram_wdata = accept ? req_wdata : '0;
`ifdef SRAM_CTRL_ZERO_INIT_EN
        sweep   = (state_q == ST_INIT) && !reset;
        sweep_d = sweep ? sweep_q + ADDR_W'(1) : sweep_q;
        state_d = (sweep && (&sweep_q)) ? ST_RUN : state_q;
        if (sweep) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_q;
            sram_wmask = '1;
            sram_wdata = '0;
        end
`else
        state_d = ST_RUN;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef SRAM_CTRL_ZERO_INIT_EN
    always_ff @(posedge clock) begin
        if (reset) sweep_q <= '0;
        else sweep_q <= sweep_d;
    end
`endif

    // The macro output tracks the array, so read data is captured the cycle after the read
    // is issued, before any following write can change it.
    sram_ctrl_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (sram_rdata),
        .pop       (rsp_valid && rsp_ready),
        .head      (rsp_rdata),
        .count     (fifo_cnt)
    );

    assign rsp_valid = fifo_cnt != '0;

endmodule
